uart_debug_tap: RTL and testbench
=================================

// Module: uart_debug_tap
// PURPOSE
//   Multi-channel UART line tap for board-level debug of the accelerator harness.
//   Mirrors N_CH UART lines to debug pins in a selectable mode (synchronised,
//   glitch-filtered, activity-stretched, or forced idle).
//   Also sniffs each line with an 8N1 receiver and exposes decoded bytes,
//   per-channel byte counts and sticky framing errors.
//   Sits beside the design top, between the board UART pins and the debug header.
// PARAMETERS
//   CLK_HZ       100000000  sys_clock frequency in Hz
//   BAUD         115200     line rate; DIV = (CLK_HZ + BAUD/2) / BAUD (868 at defaults)
//   N_CH         2          number of tapped UART lines
//   SYNC_STAGES  2          input synchroniser depth (>= 2)
//   CNT_W        16         width of each per-channel byte counter
//   STRETCH_CYC  10000000   low-pulse length in activity-stretch mode (100 ms)
// PORTS
//   sys_clock     in   1          single clock; all logic on its rising edge
//   reset         in   1          synchronous, active-high reset
//   uart_line     in   N_CH       raw asynchronous UART lines (idle high)
//   mode          in   2          00 sync, 01 filtered, 10 stretch, 11 force-idle
//   clear_counts  in   1          one-cycle pulse; clears byte_count and frame_err
//   debug_line    out  N_CH       mirrored lines to the debug header
//   byte_strobe   out  N_CH       one-cycle pulse per good byte, per channel
//   byte_data     out  8*N_CH     last good byte; ch k at [8k+7:8k]
//   byte_count    out  CNT_W*N_CH good-byte count, saturating; ch k at [CNT_W*k +: CNT_W]
//   frame_err     out  N_CH       sticky; set on stop bit sampled low
// BEHAVIOUR
//   Reset values:
//   - synchroniser stages, filter samples, debug_line: all 1
//   - byte_strobe, byte_data, byte_count, frame_err: all 0
//   - receiver FSM: IDLE
//   Sync and filter:
//   - s = last synchroniser stage.
//   - f = registered 3-sample majority of s (1-cycle glitches rejected).
//   Debug mirror (registered; mode sampled every cycle, changes take effect next cycle):
//   - 00: debug_line = s (SYNC_STAGES+1 cycles from pin).
//   - 01: debug_line = f.
//   - 10: falling edge of f loads the stretch counter with STRETCH_CYC.
//     debug_line is low while counter != 0. A new edge reloads the counter (retrigger).
//   - 11: debug_line = 1.
//   Receiver, one FSM per channel; runs on f in every mode.
//   Baud counter width = clog2(DIV).
//   - IDLE:  falling edge of f -> START; load DIV/2-1.
//   - START: at count 0, f==1 -> IDLE (false start: no strobe, no error).
//            f==0 -> DATA; bit index 0; load DIV-1.
//   - DATA:  at count 0, shift in f LSB-first. After bit 7 -> STOP; load DIV-1.
//   - STOP:  at count 0, f==1 -> 1-cycle byte_strobe, byte_data updated,
//            byte_count += 1 (holds at all-ones), -> IDLE.
//            f==0 -> frame_err=1, no strobe/count/data update, -> BREAK.
//   - BREAK: wait for f==1, then -> IDLE (a line held low never double-counts).
//   - Strobe latency: byte_strobe asserts the cycle after the stop-bit mid-sample.
//   Boundaries:
//   - clear_counts with a same-cycle strobe: clear wins (count 0, frame_err 0);
//     byte_data still updates.
//   - reset mid-frame: FSM -> IDLE and partial byte discarded;
//     a low line after reset is not a start until a falling edge is seen.
//   - Channels are fully independent; simultaneous strobes are allowed.
// TESTING
//   - Reset with lines high -> debug_line=all 1s, counts 0, no strobes, FSM IDLE.
//   - ch0 sends 0xA5 8N1 at 115200 (868 cycles/bit), mode 00 ->
//     one strobe, byte_data[7:0]=0xA5, byte_count ch0=1, ch1 unchanged.
//   - ch0 frame with stop bit low, then 0x3C ->
//     frame_err[0]=1 and sticky, count=1 (only 0x3C), no strobe for the bad frame.
//   - 300-cycle low glitch on ch1 -> false start: no strobe, no error.
//     1-cycle glitch in mode 01 -> debug_line stays 1.
//   - Mode 10, falling edges at t=0 and t=5e6 -> debug_line low until t=15e6+latency,
//     then high.
//   - Preload count 0xFFFF, send byte -> count stays 0xFFFF.
//     Pulse clear_counts on the strobe cycle -> count=0, frame_err=0.

Source files
------------

// File: rtl/uart_debug_tap.sv
// uart_debug_tap: mirrors N_CH UART lines to debug pins and sniffs each with an 8N1 receiver
module uart_debug_tap #(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 115200,
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int STRETCH_CYC = 10000000
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         uart_line,
    input  logic [1:0]              mode,
    input  logic                    clear_counts,
    output logic [N_CH-1:0]         debug_line,
    output logic [N_CH-1:0]         byte_strobe,
    output logic [8*N_CH-1:0]       byte_data,
    output logic [CNT_W*N_CH-1:0]   byte_count,
    output logic [N_CH-1:0]         frame_err
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int SW  = $clog2(STRETCH_CYC + 1);
    localparam logic [BW-1:0] HALF    = BW'(DIV / 2 - 1);
    localparam logic [BW-1:0] FULL    = BW'(DIV - 1);
    localparam logic [SW-1:0] STRETCH = SW'(STRETCH_CYC);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_e;

    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [1:0]             hist_q, hist_d;
            logic                   f_q, f_d, s, fall;
            logic [SW-1:0]          sc_q, sc_d;
            logic                   dbg_q, dbg_d;
            rx_state_e              st_q, st_d;
            logic [BW-1:0]          bc_q, bc_d;
            logic [2:0]             bi_q, bi_d;
            logic [7:0]             sh_q, sh_d, data_q, data_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   stb_q, stb_d, err_q, err_d;

            always_comb begin
                s      = sync_q[SYNC_STAGES-1];
                sync_d = {sync_q[SYNC_STAGES-2:0], uart_line[c]};
                hist_d = {hist_q[0], s};
                f_d    = (s & hist_q[0]) | (s & hist_q[1]) | (hist_q[0] & hist_q[1]);
                fall   = f_q & ~f_d;
                sc_d   = (mode == 2'b10 && fall) ? STRETCH :
                         (sc_q != '0) ? sc_q - SW'(1) : sc_q;
                dbg_d  = mode == 2'b00 ? s :
                         mode == 2'b01 ? f_q :
                         mode == 2'b10 ? (sc_q == '0) : 1'b1;
            end

            // Receiver samples the filtered line; clear_counts overrides any same-cycle update.
            always_comb begin
                st_d   = st_q;
                bc_d   = bc_q;
                bi_d   = bi_q;
                sh_d   = sh_q;
                data_d = data_q;
                cnt_d  = cnt_q;
                stb_d  = 1'b0;
                err_d  = err_q;
                case (st_q)
                    IDLE: if (fall) begin
                        st_d = START;
                        bc_d = HALF;
                    end
                    START: if (bc_q != '0) bc_d = bc_q - BW'(1);
                    else if (f_q) st_d = IDLE;
                    else begin
                        st_d = DATA;
                        bi_d = '0;
                        bc_d = FULL;
                    end
                    DATA: if (bc_q != '0) bc_d = bc_q - BW'(1);
                    else begin
                        sh_d = {f_q, sh_q[7:1]};
                        bi_d = bi_q + 3'd1;
                        bc_d = FULL;
                        if (bi_q == 3'd7) st_d = STOP;
                    end
                    STOP: if (bc_q != '0) bc_d = bc_q - BW'(1);
                    else if (f_q) begin
                        stb_d  = 1'b1;
                        data_d = sh_q;
                        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                        st_d   = IDLE;
                    end else begin
                        err_d = 1'b1;
                        st_d  = BRK;
                    end
                    default: if (f_q) st_d = IDLE;
                endcase
                if (clear_counts) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                end
            end

            always_ff @(posedge sys_clock) begin
                if (reset) begin
                    sync_q <= '1;
                    hist_q <= '1;
                    f_q    <= 1'b1;
                    sc_q   <= '0;
                    dbg_q  <= 1'b1;
                    st_q   <= IDLE;
                    bc_q   <= '0;
                    bi_q   <= '0;
                    sh_q   <= '0;
                    data_q <= '0;
                    cnt_q  <= '0;
                    stb_q  <= 1'b0;
                    err_q  <= 1'b0;
                end else begin
                    sync_q <= sync_d;
                    hist_q <= hist_d;
                    f_q    <= f_d;
                    sc_q   <= sc_d;
                    dbg_q  <= dbg_d;
                    st_q   <= st_d;
                    bc_q   <= bc_d;
                    bi_q   <= bi_d;
                    sh_q   <= sh_d;
                    data_q <= data_d;
                    cnt_q  <= cnt_d;
                    stb_q  <= stb_d;
                    err_q  <= err_d;
                end
            end

            assign debug_line[c]                = dbg_q;
            assign byte_strobe[c]               = stb_q;
            assign byte_data[8*c +: 8]          = data_q;
            assign byte_count[CNT_W*c +: CNT_W] = cnt_q;
            assign frame_err[c]                 = err_q;
        end
    endgenerate
endmodule

// File: tb/tb_uart_debug_tap.sv
// tb_uart_debug_tap: randomized 8N1 frames against a frame-level model with a strobe scoreboard
module tb_uart_debug_tap;
    localparam int DIV   = 64;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               sys_clock = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         uart_line = 2'b11;
    logic [1:0]         mode = 2'b00;
    logic               clear_counts = 1'b0;
    logic [1:0]         debug_line, byte_strobe, frame_err;
    logic [15:0]        byte_data;
    logic [2*CNT_W-1:0] byte_count;

    int vectors = 0;
    int miscompares = 0;
    int exp0[$];
    int exp1[$];
    int mcnt[2];
    logic [1:0] merr;

    uart_debug_tap #(
        .CLK_HZ(100000000), .BAUD(1562500), .N_CH(2), .SYNC_STAGES(2),
        .CNT_W(CNT_W), .STRETCH_CYC(1000)
    ) dut (
        .sys_clock(sys_clock), .reset(reset), .uart_line(uart_line), .mode(mode),
        .clear_counts(clear_counts), .debug_line(debug_line), .byte_strobe(byte_strobe),
        .byte_data(byte_data), .byte_count(byte_count), .frame_err(frame_err)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    task automatic send(input int c, input logic [7:0] b, input logic stop);
        uart_line[c] = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_line[c] = b[i];
            idle(DIV);
        end
        uart_line[c] = stop;
        idle(DIV);
        uart_line[c] = 1'b1;
        idle(2 * DIV);
    endtask

    task automatic frame(input int c, input logic [7:0] b, input logic stop);
        if (stop) begin
            mcnt[c] = (mcnt[c] == CMAX) ? CMAX : mcnt[c] + 1;
            if (c == 0) exp0.push_back(mcnt[c] * 256 + int'(b));
            else exp1.push_back(mcnt[c] * 256 + int'(b));
        end else merr[c] = 1'b1;
        send(c, b, stop);
    endtask

    task automatic check_state(input string tag);
        for (int c = 0; c < 2; c++) begin
            check($sformatf("%s count ch%0d", tag, c), 32'(byte_count[CNT_W*c +: CNT_W]), 32'(mcnt[c]));
            check($sformatf("%s frame_err ch%0d", tag, c), 32'(frame_err[c]), 32'(merr[c]));
        end
    endtask

    task automatic pulse(input int c, input int n);
        uart_line[c] = 1'b0;
        idle(n);
        uart_line[c] = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge sys_clock);
            for (int c = 0; c < 2; c++) begin
                if (byte_strobe[c]) begin
                    int e;
                    if ((c == 0 ? exp0.size() : exp1.size()) == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected strobe ch%0d: got 1 expected 0", c);
                    end else begin
                        e = (c == 0) ? exp0.pop_front() : exp1.pop_front();
                        check($sformatf("strobe data ch%0d", c), 32'(byte_data[8*c +: 8]), 32'(e % 256));
                        check($sformatf("strobe count ch%0d", c), 32'(byte_count[CNT_W*c +: CNT_W]), 32'(e / 256));
                    end
                end
            end
        end
    end

    initial begin
        mcnt[0] = 0;
        mcnt[1] = 0;
        merr = 2'b00;
        idle(4);
        reset = 1'b0;
        idle(2);
        check("reset debug_line", 32'(debug_line), 32'h3);
        check("reset strobe", 32'(byte_strobe), 32'h0);
        check("reset data", 32'(byte_data), 32'h0);
        check_state("reset");

        frame(0, 8'hA5, 1'b1);
        check_state("after A5");

        // 5-cycle low pulse: mirror latency then a false start
        uart_line[1] = 1'b0;
        idle(2);
        check("sync latency early", 32'(debug_line[1]), 32'h1);
        idle(1);
        check("sync latency edge", 32'(debug_line[1]), 32'h0);
        idle(2);
        uart_line[1] = 1'b1;
        idle(200);
        check_state("short pulse");

        frame(0, 8'($urandom), 1'b0);
        check_state("bad stop");
        frame(0, 8'h3C, 1'b1);
        check_state("after 3C");

        pulse(1, $urandom_range(3, 20));
        idle(200);
        check_state("glitch false start");

        mode = 2'b01;
        idle(10);
        pulse(1, 1);
        for (int i = 0; i < 8; i++) begin
            check("filtered glitch", 32'(debug_line[1]), 32'h1);
            idle(1);
        end

        mode = 2'b11;
        idle(2);
        uart_line[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("force idle", 32'(debug_line), 32'h3);
        end
        uart_line[0] = 1'b1;
        idle(100);

        mode = 2'b10;
        idle(5);
        check("stretch quiet", 32'(debug_line), 32'h3);
        pulse(0, 10);
        idle(290);
        check("stretch low", 32'(debug_line[0]), 32'h0);
        idle(200);
        pulse(0, 10);
        idle(790);
        check("stretch retriggered", 32'(debug_line[0]), 32'h0);
        idle(180);
        check("stretch near end", 32'(debug_line[0]), 32'h0);
        check("stretch other ch", 32'(debug_line[1]), 32'h1);
        idle(50);
        check("stretch expired", 32'(debug_line[0]), 32'h1);
        mode = 2'b00;
        idle(100);
        check_state("after stretch");

        for (int n = 0; n < 8; n++) begin
            int r;
            r = $urandom_range(0, 2);
            if (r == 2) begin
                fork
                    frame(0, 8'($urandom), $urandom_range(0, 3) != 0);
                    frame(1, 8'($urandom), $urandom_range(0, 3) != 0);
                join
            end else frame(r, 8'($urandom), $urandom_range(0, 3) != 0);
            check_state($sformatf("random %0d", n));
        end

        for (int n = 0; n < 4; n++) frame(1, 8'($urandom), 1'b1);
        check_state("saturated");

        begin
            logic [7:0] b;
            b = 8'($urandom);
            exp1.push_back(int'(b));
            fork
                send(1, b, 1'b1);
                begin
                    idle(590);
                    clear_counts = 1'b1;
                    idle(40);
                    clear_counts = 1'b0;
                end
            join
            mcnt[0] = 0;
            mcnt[1] = 0;
            merr = 2'b00;
            check_state("clear on strobe");
            check("clear keeps data", 32'(byte_data[15:8]), 32'(b));
        end

        uart_line[0] = 1'b0;
        idle(DIV);
        uart_line[0] = 1'b1;
        idle(DIV);
        uart_line[0] = 1'b0;
        idle(100);
        reset = 1'b1;
        uart_line[0] = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(5 * DIV);
        check("midframe reset data", 32'(byte_data), 32'h0);
        check_state("midframe reset");
        frame(0, 8'($urandom), 1'b1);
        check_state("after reset recovery");

        check("pending ch0", 32'(exp0.size()), 32'h0);
        check("pending ch1", 32'(exp1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
